divisor_datapath: RTL and testbench

Datapath for the calculator's sequential unsigned integer divider, using a compare-and-subtract algorithm. It sits beside the divider control FSM. It executes that FSM's strobes (INIT, SH, DEC, LDA, DV0) and returns the two status flags the FSM branches on (MSB, Z). It also holds the quotient and remainder read by the calculator top level when DONE is asserted.

---
 rtl/divisor_pkg.sv | 24 ++
 rtl/divisor_datapath_if.sv | 44 ++++
 rtl/divisor_sub.sv | 21 ++
 rtl/divisor_datapath.sv | 79 +++++++
 tb/tb_divisor_datapath.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential divider: default operand width,
// bit-counter sizing and the layout of the divider's status flags inside
// the calculator status word.
package divisor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bit positions of the divider flags in the calculator status word.
  localparam int STATUS_MSB_BIT  = 0;
  localparam int STATUS_Z_BIT    = 1;
  localparam int STATUS_DIV0_BIT = 2;

  typedef struct packed {
    logic div0;
    logic z;
    logic msb;
  } div_status_t;

  // The counter must hold the value WIDTH itself, hence WIDTH+1 states.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divisor_datapath_if.sv
// Bundle between the divider control FSM (master) and the divider
// datapath (slave).
//
// Command semantics: INIT, SH, DEC, LDA and DV0 are single-cycle strobes
// with no handshake; each acts on the rising edge where it is sampled
// high and the datapath accepts one command set every cycle. MSB, Z and
// DIV0 are combinational from the registers and are valid in the cycle
// after a strobe. QUOTIENT/REMAINDER are meaningful once the controller
// has seen Z in its check state. dbg_a/dbg_cnt expose internal state for
// observation only.
interface divisor_datapath_if
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic             INIT;
  logic             SH;
  logic             DEC;
  logic             LDA;
  logic             DV0;
  logic             MSB;
  logic             Z;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             DIV0;
  logic [WIDTH:0]   dbg_a;
  logic [CNT_W-1:0] dbg_cnt;

  modport master (
    output DIVIDEND, DIVISOR, INIT, SH, DEC, LDA, DV0,
    input  MSB, Z, QUOTIENT, REMAINDER, DIV0, dbg_a, dbg_cnt
  );

  modport slave (
    input  DIVIDEND, DIVISOR, INIT, SH, DEC, LDA, DV0,
    output MSB, Z, QUOTIENT, REMAINDER, DIV0, dbg_a, dbg_cnt
  );

endinterface

// File: rtl/divisor_sub.sv
// WIDTH+2-bit compare-and-subtract: A - D with an extra guard bit so the
// top bit is a clean borrow (1 means A < D). Shared with the modulo path.
module divisor_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   diff,
  output logic             msb
);

  logic [WIDTH+1:0] full_diff;

  // Zero-extend both operands to WIDTH+2 bits so the borrow lands in the top bit.
  always_comb begin
    full_diff = {1'b0, a} - {2'b00, d};
    diff      = full_diff[WIDTH:0];
    msb       = full_diff[WIDTH+1];
  end

endmodule

// File: rtl/divisor_datapath.sv
// Datapath of the sequential unsigned divider. Executes the control
// FSM's strobes on the partial remainder A, the dividend/quotient B, the
// latched divisor D and the bit counter CNT, and reports MSB/Z/DIV0.
module divisor_datapath
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  divisor_datapath_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   diff;
  logic             msb;

  divisor_sub #(.WIDTH(WIDTH)) u_sub (
    .a    (a_q),
    .d    (d_q),
    .diff (diff),
    .msb  (msb)
  );

  // Next-state mux: INIT beats everything, SH beats LDA/DV0, DEC is independent.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (bus.INIT) begin
      a_d   = '0;
      b_d   = bus.DIVIDEND;
      d_d   = bus.DIVISOR;
      cnt_d = CNT_W'(WIDTH);
    end else begin
      if (bus.SH) begin
        // A stays below 2*D after a shift, so dropping A[WIDTH] loses nothing.
        {a_d, b_d} = {a_q[WIDTH-1:0], b_q, 1'b0};
      end else begin
        if (bus.LDA) a_d = diff;
        if (bus.DV0) b_d[0] = 1'b1;
      end
      if (bus.DEC && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers; reset clears everything, a new INIT is needed afterwards.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  // Status flags and results are read straight from the registers.
  always_comb begin
    bus.MSB       = msb;
    bus.Z         = (cnt_q == '0);
    bus.DIV0      = (d_q == '0);
    bus.QUOTIENT  = b_q;
    bus.REMAINDER = a_q[WIDTH-1:0];
    bus.dbg_a     = a_q;
    bus.dbg_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_divisor_datapath.sv
// Bench for divisor_datapath: a behavioural controller drives the
// SH+DEC / check / LDA+DV0 sequence, expected results come from plain
// integer division and are queued; a monitor compares on each done pulse.
module tb_divisor_datapath;
  import divisor_pkg::*;

  localparam int W  = 8;
  localparam int RW = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  divisor_datapath_if #(.WIDTH(W)) bus ();

  divisor_datapath #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];
  logic done = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference: {div0, quotient, remainder} from integer arithmetic.
  function automatic logic [RW-1:0] ref_div(logic [W-1:0] n, logic [W-1:0] d);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (d == 0) return {1'b1, {W{1'b1}}, n};
    q = n / d;
    r = n % d;
    return {1'b0, q, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_strobes();
    bus.INIT = 1'b0;
    bus.SH   = 1'b0;
    bus.DEC  = 1'b0;
    bus.LDA  = 1'b0;
    bus.DV0  = 1'b0;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_msb"},  bus.MSB, 0);
    chk({tag, "_z"},    bus.Z, 1);
    chk({tag, "_quot"}, bus.QUOTIENT, 0);
    chk({tag, "_rem"},  bus.REMAINDER, 0);
    chk({tag, "_div0"}, bus.DIV0, 1);
    chk({tag, "_cnt"},  bus.dbg_cnt, 0);
    chk({tag, "_a"},    bus.dbg_a, 0);
  endtask

  // Runs one division; abort_iter >= 0 drops reset before that iteration.
  task automatic run_division(logic [W-1:0] n, logic [W-1:0] d, int abort_iter);
    logic [W-1:0] q_exp;
    logic msb;
    logic z;
    int it;
    q_exp = (d == 0) ? {W{1'b1}} : W'(n / d);
    if (abort_iter < 0) exp_q.push_back(ref_div(n, d));
    clear_strobes();
    bus.DIVIDEND = n;
    bus.DIVISOR  = d;
    bus.INIT     = 1'b1;
    step();
    bus.INIT = 1'b0;
    it = 0;
    z  = 1'b0;
    while (!z) begin
      if (it == abort_iter) begin
        #1 RST_N = 1'b0;
        #1;
        check_reset_vals("abort");
        step();
        RST_N = 1'b1;
        step();
        return;
      end
      if (it >= W) begin
        n_checks++;
        $display("FAIL iter_budget: got %0d iterations expected at most %0d", it, W);
        return;
      end
      // Operand inputs are ignored outside INIT, so scramble them.
      bus.DIVIDEND = W'($urandom);
      bus.DIVISOR  = W'($urandom);
      bus.SH  = 1'b1;
      bus.DEC = 1'b1;
      step();
      bus.SH  = 1'b0;
      bus.DEC = 1'b0;
      msb = bus.MSB;
      z   = bus.Z;
      // Quotient bits come out MSB first; MSB=1 means that bit is zero.
      chk("msb_bit", msb, !q_exp[W-1-it]);
      chk("z_flag", z, (it == W - 1));
      step();
      if (!msb) begin
        bus.LDA = 1'b1;
        bus.DV0 = 1'b1;
        step();
        bus.LDA = 1'b0;
        bus.DV0 = 1'b0;
      end
      it++;
    end
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    logic [RW-1:0] exp;
    @(posedge done);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL result: got result with empty queue expected none");
    end else begin
      exp = exp_q.pop_front();
      chk("result", {bus.DIV0, bus.QUOTIENT, bus.REMAINDER}, exp);
      chk("z_end", bus.Z, 1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    int shifted;
    RST_N = 1'b0;
    bus.DIVIDEND = '0;
    bus.DIVISOR  = '0;
    clear_strobes();
    step();
    step();
    check_reset_vals("reset");
    RST_N = 1'b1;
    step();

    run_division(8'd100, 8'd7, -1);
    run_division(8'd255, 8'd1, -1);
    run_division(8'd5,   8'd9, -1);
    run_division(8'd37,  8'd0, -1);

    // INIT with every other strobe: only INIT acts.
    bus.DIVIDEND = 8'hAA;
    bus.DIVISOR  = 8'd3;
    bus.INIT = 1'b1; bus.SH = 1'b1; bus.DEC = 1'b1; bus.LDA = 1'b1; bus.DV0 = 1'b1;
    step();
    clear_strobes();
    chk("init_prio_cnt",  bus.dbg_cnt, W);
    chk("init_prio_a",    bus.dbg_a, 0);
    chk("init_prio_b",    bus.QUOTIENT, 8'hAA);
    chk("init_prio_div0", bus.DIV0, 0);
    chk("init_prio_z",    bus.Z, 0);

    // SH with LDA/DV0: {A,B} simply doubles.
    bus.SH = 1'b1; bus.LDA = 1'b1; bus.DV0 = 1'b1;
    step();
    clear_strobes();
    shifted = 8'hAA * 2;
    chk("sh_prio_b", bus.QUOTIENT, shifted % 256);
    chk("sh_prio_a", bus.dbg_a, shifted / 256);

    // LDA+DV0 alone: A = (1 - 3) mod 2^(W+1), B gets bit 0 set.
    bus.LDA = 1'b1; bus.DV0 = 1'b1;
    step();
    clear_strobes();
    chk("lda_a", bus.dbg_a, (1 - 3 + 512) % 512);
    chk("dv0_b", bus.QUOTIENT, (shifted % 256) + 1);

    // DEC saturation.
    bus.INIT = 1'b1;
    step();
    clear_strobes();
    for (int k = 1; k <= 10; k++) begin
      bus.DEC = 1'b1;
      step();
      bus.DEC = 1'b0;
      chk("dec_cnt", bus.dbg_cnt, (W - k > 0) ? W - k : 0);
    end
    chk("dec_z", bus.Z, 1);

    // Reset mid-division, then a clean rerun.
    run_division(8'd200, 8'd3, 4);
    run_division(8'd200, 8'd3, -1);

    // INIT mid-division restarts with the new operands.
    bus.DIVIDEND = 8'd50;
    bus.DIVISOR  = 8'd5;
    bus.INIT = 1'b1;
    step();
    clear_strobes();
    for (int k = 0; k < 3; k++) begin
      bus.SH = 1'b1; bus.DEC = 1'b1;
      step();
      clear_strobes();
    end
    run_division(8'd173, 8'd12, -1);

    // Random operands, with occasional zero divisors.
    for (int i = 0; i < 30; i++) begin
      rn = W'($urandom_range(0, 255));
      rd = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      run_division(rn, rd, -1);
    end

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
